// File: rtl/uart_pkg.sv
// Shared UART defaults: data word width, FIFO address width, and the
// helper that sizes the FIFO level counter.
package uart_pkg;

    localparam int UART_DATA_W    = 8;
    localparam int UART_ADDR_SIZE = 4;

    // The level counter must represent 0..2**addr_size, which needs one extra bit.
    function automatic int uart_lvl_w(input int addr_size);
        return addr_size + 1;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// UART FIFO storage: one synchronous write port and one asynchronous read port.
// Contents are never reset, so unwritten entries read as X in simulation.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DATA_UART = UART_DATA_W,
    parameter int ADDR_SIZE = UART_ADDR_SIZE
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [ADDR_SIZE-1:0] waddr_i,
    input  logic [DATA_UART-1:0] wdata_i,
    input  logic [ADDR_SIZE-1:0] raddr_i,
    output logic [DATA_UART-1:0] rdata_o
);

    localparam int DEPTH = 2 ** ADDR_SIZE;

    logic [DATA_UART-1:0] mem_q [DEPTH];

    // Write port: store the word at the write pointer on an accepted push.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // The read port is combinational so the head word falls through to the output.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_fifo.sv
// UART FIFO: first-word-fall-through buffer between the UART engine and its host.
// Pointer, level and flag logic live here; storage is held in uart_fifo_mem.
// Optional feature: define UART_FIFO_OVERRUN_EN to enable the sticky overrun flag.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int DATA_UART = UART_DATA_W,
    parameter int ADDR_SIZE = UART_ADDR_SIZE
) (
    input  logic                             clk_i,
    input  logic                             rstn_i,
    input  logic                             flush_i,
    input  logic                             push_i,
    input  logic [DATA_UART-1:0]             push_data_i,
    output logic                             full_o,
    input  logic                             pull_i,
    output logic [DATA_UART-1:0]             pull_data_o,
    output logic                             load_o,
    output logic                             empty_o,
    output logic [uart_lvl_w(ADDR_SIZE)-1:0] level_o,
    output logic                             overrun_o,
    input  logic                             overrun_clr_i
);

    localparam int LW    = uart_lvl_w(ADDR_SIZE);
    localparam int DEPTH = 2 ** ADDR_SIZE;

    localparam logic [ADDR_SIZE-1:0] PTR_ONE = 1;
    localparam logic [LW-1:0]        LVL_ONE = 1;
    localparam logic [LW-1:0]        LVL_MAX = LW'(DEPTH);

    logic [ADDR_SIZE-1:0] wptr_q, wptr_d;
    logic [ADDR_SIZE-1:0] rptr_q, rptr_d;
    logic [LW-1:0]        level_q, level_d;
    logic                 pull_ok, push_ok;

    // Status flags derive from the registered level, never from pointer equality.
    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LVL_MAX);
    assign load_o  = ~empty_o;
    assign level_o = level_q;

    // A pull only counts when there is a head; a push into a full FIFO
    // is accepted only if a real pull frees a slot in the same cycle.
    assign pull_ok = pull_i & load_o;
    assign push_ok = push_i & (~full_o | pull_ok);

    // Next-state for pointers and level; flush overrides everything.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (push_ok) wptr_d = wptr_q + PTR_ONE;
            if (pull_ok) rptr_d = rptr_q + PTR_ONE;
            case ({push_ok, pull_ok})
                2'b10:   level_d = level_q + LVL_ONE;
                2'b01:   level_d = level_q - LVL_ONE;
                default: level_d = level_q;
            endcase
        end
    end

    // Pointer and level registers; reset discards all entries immediately.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

`ifdef UART_FIFO_OVERRUN_EN
    logic overrun_q, overrun_d;
    logic push_rej;

    // A push is rejected when the FIFO is full and no pull makes room.
    assign push_rej = push_i & full_o & ~pull_ok;

    // Sticky overrun: a new rejection wins over a clear; flush clears it.
    always_comb begin
        overrun_d = overrun_q;
        if (flush_i)            overrun_d = 1'b0;
        else if (push_rej)      overrun_d = 1'b1;
        else if (overrun_clr_i) overrun_d = 1'b0;
    end

    // Overrun flag register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) overrun_q <= 1'b0;
        else         overrun_q <= overrun_d;
    end

    assign overrun_o = overrun_q;
`else
    logic unused_overrun_clr;

    assign unused_overrun_clr = overrun_clr_i;
    assign overrun_o          = 1'b0;
`endif

    uart_fifo_mem #(
        .DATA_UART (DATA_UART),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (push_ok & ~flush_i),
        .waddr_i (wptr_q),
        .wdata_i (push_data_i),
        .raddr_i (rptr_q),
        .rdata_o (pull_data_o)
    );

endmodule

// File: tb/tb_uart_fifo.sv
// Directed self-checking bench for uart_fifo (default parameters).
module tb_uart_fifo;

    logic       clk_i = 1'b0;
    logic       rstn_i, flush_i, push_i, pull_i, overrun_clr_i;
    logic [7:0] push_data_i;
    logic       full_o, load_o, empty_o, overrun_o;
    logic [7:0] pull_data_o;
    logic [4:0] level_o;

    int errors = 0;
    int checks = 0;

`ifdef UART_FIFO_OVERRUN_EN
    localparam logic OVR_EXP = 1'b1;
`else
    localparam logic OVR_EXP = 1'b0;
`endif

    always #5 clk_i = ~clk_i;

    uart_fifo dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .flush_i       (flush_i),
        .push_i        (push_i),
        .push_data_i   (push_data_i),
        .full_o        (full_o),
        .pull_i        (pull_i),
        .pull_data_o   (pull_data_o),
        .load_o        (load_o),
        .empty_o       (empty_o),
        .level_o       (level_o),
        .overrun_o     (overrun_o),
        .overrun_clr_i (overrun_clr_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic push, input logic [7:0] data, input logic pull,
                        input logic flush = 1'b0, input logic clr = 1'b0);
        push_i = push; push_data_i = data; pull_i = pull;
        flush_i = flush; overrun_clr_i = clr;
        @(posedge clk_i);
        #1;
        push_i = 1'b0; pull_i = 1'b0; flush_i = 1'b0; overrun_clr_i = 1'b0;
    endtask

    initial begin
        logic [7:0] q[$];
        logic       do_pull, p_ok, w_ok;

        rstn_i = 1'b0; flush_i = 1'b0; push_i = 1'b0; pull_i = 1'b0;
        overrun_clr_i = 1'b0; push_data_i = 8'h00;
        #12;
        chk("rst_empty", empty_o, 1); chk("rst_full", full_o, 0);
        chk("rst_load", load_o, 0); chk("rst_level", level_o, 0);
        chk("rst_ovr", overrun_o, 0);
        @(negedge clk_i); rstn_i = 1'b1;

        // Two pushes, then pull
        step(1, 8'hA5, 0);
        chk("p1_load", load_o, 1); chk("p1_data", pull_data_o, 8'hA5);
        step(1, 8'h3C, 0);
        chk("p2_level", level_o, 2); chk("p2_data", pull_data_o, 8'hA5);
        step(0, 0, 1);
        chk("pl_data", pull_data_o, 8'h3C); chk("pl_level", level_o, 1);
        step(0, 0, 1);
        chk("pl_empty", empty_o, 1);

        // Fill to full, reject 17th push, drain in order
        for (int i = 0; i < 16; i++) step(1, 8'(i), 0);
        chk("fill_full", full_o, 1); chk("fill_level", level_o, 16);
        step(1, 8'hFF, 0);
        chk("rej_level", level_o, 16); chk("rej_ovr", overrun_o, OVR_EXP);
        chk("rej_head", pull_data_o, 8'h00);
        step(0, 0, 0, 0, 1);
        chk("ovr_clr", overrun_o, 0);
        for (int i = 0; i < 16; i++) begin
            chk("drain_data", pull_data_o, 32'(i));
            step(0, 0, 1);
        end
        chk("drain_empty", empty_o, 1);

        // Full FIFO: push with pull keeps level
        for (int i = 0; i < 16; i++) step(1, 8'(8'h80 + i), 0);
        step(1, 8'h55, 1);
        chk("pp_level", level_o, 16); chk("pp_full", full_o, 1);
        chk("pp_ovr", overrun_o, 0); chk("pp_head", pull_data_o, 8'h81);
        for (int i = 1; i < 16; i++) begin
            chk("pp_drain", pull_data_o, 32'(8'h80 + i));
            step(0, 0, 1);
        end
        chk("pp_last", pull_data_o, 8'h55); chk("pp_last_lvl", level_o, 1);
        step(0, 0, 1);
        chk("pp_empty", empty_o, 1);

        // Pull on empty, then push+pull on empty
        step(0, 0, 1);
        chk("pe_level", level_o, 0); chk("pe_empty", empty_o, 1);
        step(1, 8'h77, 1);
        chk("pe2_level", level_o, 1); chk("pe2_data", pull_data_o, 8'h77);
        step(0, 0, 1);

        // 40 pushes with interleaved pulls against a queue model
        for (int i = 0; i < 40; i++) begin
            do_pull = (i % 3) != 0;
            p_ok = do_pull && (q.size() > 0);
            w_ok = (q.size() < 16) || p_ok;
            if (p_ok) begin
                chk("wrap_pop", pull_data_o, q[0]);
                void'(q.pop_front());
            end
            if (w_ok) q.push_back(8'(8'h20 + i));
            step(1, 8'(8'h20 + i), do_pull);
            chk("wrap_level", level_o, q.size());
            if (q.size() > 0) chk("wrap_head", pull_data_o, q[0]);
        end
        while (q.size() > 0) begin
            chk("wrap_drain", pull_data_o, q[0]);
            void'(q.pop_front());
            step(0, 0, 1);
            chk("wrap_dlvl", level_o, q.size());
        end

        // Flush with push
        step(1, 8'h01, 0); step(1, 8'h02, 0);
        step(1, 8'h11, 0, 1);
        chk("fl_level", level_o, 0); chk("fl_empty", empty_o, 1);

        // Async reset with 5 entries
        for (int i = 0; i < 5; i++) step(1, 8'(8'h60 + i), 0);
        chk("pre_rst_lvl", level_o, 5);
        #2 rstn_i = 1'b0;
        #1;
        chk("arst_empty", empty_o, 1); chk("arst_ovr", overrun_o, 0);
        chk("arst_level", level_o, 0);
        @(negedge clk_i); rstn_i = 1'b1;
        step(0, 0, 0);
        chk("post_rst_empty", empty_o, 1);
        step(1, 8'h42, 0);
        chk("post_rst_data", pull_data_o, 8'h42); chk("post_rst_lvl", level_o, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_fifo.md
UART_FIFO -- requirements
Module: uart_fifo

Interface
REQ-001 The block SHALL have parameter DATA_UART, default 8, giving the width of one UART data word.
REQ-002 The block SHALL have parameter ADDR_SIZE, default 4, giving the log2 of the FIFO depth (DEPTH = 2**ADDR_SIZE = 16).
REQ-003 The block SHALL have port clk_i, input, 1 bit: clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rstn_i, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port flush_i, input, 1 bit: synchronous clear of all entries.
REQ-006 The block SHALL have port push_i, input, 1 bit: write push_data_i this cycle.
REQ-007 The block SHALL have port push_data_i, input, DATA_UART bits: word to write.
REQ-008 The block SHALL have port full_o, output, 1 bit: level == DEPTH.
REQ-009 The block SHALL have port pull_i, input, 1 bit: pop the head entry this cycle.
REQ-010 The block SHALL have port pull_data_o, output, DATA_UART bits: head entry, first-word-fall-through.
REQ-011 The block SHALL have port load_o, output, 1 bit: FIFO not empty (head valid).
REQ-012 The block SHALL have port empty_o, output, 1 bit: level == 0.
REQ-013 The block SHALL have port level_o, output, ADDR_SIZE+1 bits: current entry count, 0..DEPTH.
REQ-014 The block SHALL have port overrun_o, output, 1 bit: sticky overrun error flag.
REQ-015 The block SHALL have port overrun_clr_i, input, 1 bit: clear overrun_o.

Function
REQ-016 pull_data_o SHALL combinationally present the oldest stored word whenever load_o = 1, so that a consumer sampling it with a one-cycle-late pull pulse receives the correct word.
REQ-017 A push SHALL be accepted when push_i = 1 and either full_o = 0 or pull_i = 1 with load_o = 1 in the same cycle.
REQ-018 A pull SHALL take effect only when pull_i = 1 and load_o = 1; a pull while empty SHALL be ignored, with no state change and no flag.
REQ-019 An accepted push without a pull SHALL increment level_o by 1; a pull without a push SHALL decrement it by 1; a simultaneous accepted push and pull SHALL leave it unchanged.
REQ-020 Push with pull on an empty FIFO SHALL store the word, ignore the pull, and raise load_o on the next cycle.
REQ-021 Read and write pointers SHALL be ADDR_SIZE bits and wrap modulo DEPTH; full and empty SHALL be derived from level_o, not from pointer equality.
REQ-022 full_o, empty_o and load_o SHALL be registered-state-derived and valid in the cycle after the causing edge (one-cycle latency push→load_o).
REQ-023 flush_i SHALL have priority over push_i and pull_i: the next state SHALL be pointers = 0, level = 0, and the push is dropped.
REQ-024 Memory contents SHALL NOT be reset or cleared by flush; only pointers and level SHALL be.

Reset
REQ-025 During rstn_i = 0, outputs SHALL be: full_o = 0, empty_o = 1, load_o = 0, level_o = 0, overrun_o = 0, and pull_data_o don't-care (X permitted).
REQ-026 Reset asserted mid-transfer SHALL discard all entries immediately; the first edge after release SHALL behave as a normal idle cycle.

Configuration
REQ-027 Macro UART_FIFO_OVERRUN_EN, when defined, SHALL set overrun_o on the cycle after a push_i is rejected because the FIFO is full with no accepted pull, and overrun_o SHALL then hold until overrun_clr_i = 1 or flush_i = 1. If overrun_clr_i and a new rejected push coincide, overrun_o SHALL stay 1.
REQ-028 When UART_FIFO_OVERRUN_EN is undefined, overrun_o SHALL be tied 0, overrun_clr_i SHALL be ignored, and rejected pushes SHALL still be dropped silently.

Structure
REQ-029 Default DATA_UART, ADDR_SIZE and the level width function SHALL live in the shared package uart_pkg.
REQ-030 Storage SHALL be a sub-module uart_fifo_mem with one synchronous write port and one asynchronous read port; pointer, level and flag logic SHALL reside in uart_fifo.
REQ-031 One instance SHALL feed uart_controller (load_o→tx_load_i, full_o→tx_full_i, pull_data_o→tx_data_i, tx_pull_o→pull_i); a second SHALL accept rx_push_o/rx_data_o as push_i/push_data_i.

Verification
REQ-032 Push 0xA5, then 0x3C -> load_o = 1 one cycle after the first push; pull_data_o = 0xA5; after a one-cycle pull, pull_data_o = 0x3C and level_o = 1.
REQ-033 Push 16 words 0x00..0x0F -> full_o = 1, level_o = 16; a 17th push 0xFF is dropped, overrun_o = 1 (macro on) or 0 (macro off); drain returns 0x00..0x0F in order.
REQ-034 With the FIFO full, push 0x55 together with pull -> level_o stays 16, full_o stays 1, and 0x55 appears last after 15 further pulls.
REQ-035 Pull on empty -> no change; push 0x77 together with pull on empty -> level_o = 1, pull_data_o = 0x77.
REQ-036 Fill 40 words with interleaved pulls (pointer wrap twice) -> data order preserved and level_o matches a scoreboard every cycle.
REQ-037 flush_i asserted together with push 0x11 -> level_o = 0, empty_o = 1 next cycle; rstn_i pulsed with 5 entries -> empty_o = 1 asynchronously and overrun_o = 0.
